// File: rtl/regfile_2r1w_pkg.sv
// regfile_2r1w_pkg
//   Shared constants for the 2-read / 1-write register file and its
//   write-enable decoder.
//   WIDTH_DEF      : default data width of every register and data port
//   ADDR_WIDTH_DEF : default register index width
//   DEPTH_DEF      : number of architectural registers (2**ADDR_WIDTH_DEF)
//   REG_ZERO       : index of the hardwired-zero register
package regfile_2r1w_pkg;

  localparam int WIDTH_DEF      = 32;
  localparam int ADDR_WIDTH_DEF = 5;
  localparam int DEPTH_DEF      = 2 ** ADDR_WIDTH_DEF;
  localparam int REG_ZERO       = 0;

endpackage

// File: rtl/regfile_2r1w_decoder_1to32.sv
// decoder_1to32
//   One-hot write-enable decoder for the register file. When enable is high,
//   exactly one line (selected by address) is driven high. Line REG_ZERO is
//   always held low because register 0 has no storage.
//   Ports:
//     enable  in   1           global write enable (RegWrite)
//     address in   ADDR_WIDTH  register index to enable (WriteRegister)
//     lines   out  2**ADDR_WIDTH  one-hot enable lines, line 0 forced low
module decoder_1to32
  import regfile_2r1w_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
  input  logic                         enable,
  input  logic [ADDR_WIDTH-1:0]        address,
  output logic [(2**ADDR_WIDTH)-1:0]   lines
);

  always_comb begin
    lines = '0;
    if (enable) begin
      lines[address] = 1'b1;
    end
    lines[REG_ZERO] = 1'b0;
  end

endmodule

// File: rtl/regfile_2r1w.sv
// regfile_2r1w
//   32 x 32 general-purpose register file: two combinational read ports and
//   one clocked write port. Register 0 reads as constant zero and has no
//   storage. Reset is synchronous, active-high, and overrides any write in
//   the same cycle. There is no write-to-read bypass: a read of the register
//   being written returns the old value until the clock edge.
//   Ports:
//     clk            in   1           system clock, rising-edge active
//     reset          in   1           synchronous active-high clear
//     RegWrite       in   1           write enable
//     WriteRegister  in   ADDR_WIDTH  write index
//     WriteData      in   WIDTH       write data
//     ReadRegister1  in   ADDR_WIDTH  read port 1 index
//     ReadRegister2  in   ADDR_WIDTH  read port 2 index
//     ReadData1      out  WIDTH       read port 1 data
//     ReadData2      out  WIDTH       read port 2 data
module regfile_2r1w
  import regfile_2r1w_pkg::*;
#(
  parameter int WIDTH      = WIDTH_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  RegWrite,
  input  logic [ADDR_WIDTH-1:0] WriteRegister,
  input  logic [WIDTH-1:0]      WriteData,
  input  logic [ADDR_WIDTH-1:0] ReadRegister1,
  input  logic [ADDR_WIDTH-1:0] ReadRegister2,
  output logic [WIDTH-1:0]      ReadData1,
  output logic [WIDTH-1:0]      ReadData2
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DEPTH-1:0]          we;
  logic [DEPTH-1:1][WIDTH-1:0] store;

  // Line 0 of the decoder is always low; it is kept only so the decoder
  // presents a full one-hot vector.
  logic line0_unused;
  assign line0_unused = we[REG_ZERO];

  decoder_1to32 #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_decoder (
    .enable  (RegWrite),
    .address (WriteRegister),
    .lines   (we)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      store <= '0;
    end else begin
      for (int i = 1; i < DEPTH; i++) begin
        if (we[i]) begin
          store[i] <= WriteData;
        end
      end
    end
  end

  // Index 0 falls through to the zero default because store has no entry 0.
  always_comb begin
    ReadData1 = '0;
    for (int i = 1; i < DEPTH; i++) begin
      if (ReadRegister1 == ADDR_WIDTH'(i)) begin
        ReadData1 = store[i];
      end
    end
  end

  always_comb begin
    ReadData2 = '0;
    for (int i = 1; i < DEPTH; i++) begin
      if (ReadRegister2 == ADDR_WIDTH'(i)) begin
        ReadData2 = store[i];
      end
    end
  end

endmodule

// File: tb/tb_regfile_2r1w.sv
module tb_regfile_2r1w;

  logic        clk;
  logic        reset;
  logic        RegWrite;
  logic [4:0]  WriteRegister;
  logic [31:0] WriteData;
  logic [4:0]  ReadRegister1;
  logic [4:0]  ReadRegister2;
  logic [31:0] ReadData1;
  logic [31:0] ReadData2;

  int n_vec;
  int n_miss;

  regfile_2r1w dut (
    .clk           (clk),
    .reset         (reset),
    .RegWrite      (RegWrite),
    .WriteRegister (WriteRegister),
    .WriteData     (WriteData),
    .ReadRegister1 (ReadRegister1),
    .ReadRegister2 (ReadRegister2),
    .ReadData1     (ReadData1),
    .ReadData2     (ReadData2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One write presented at the negedge, committed at the following posedge.
  task automatic wr(input logic [4:0] addr, input logic [31:0] data);
    @(negedge clk);
    RegWrite      = 1'b1;
    WriteRegister = addr;
    WriteData     = data;
    @(posedge clk);
    #1;
    RegWrite = 1'b0;
  endtask

  task automatic rd(input logic [4:0] a1, input logic [4:0] a2);
    ReadRegister1 = a1;
    ReadRegister2 = a2;
    #1;
  endtask

  task automatic sweep_zero(input string tag);
    for (int i = 0; i < 32; i++) begin
      rd(5'(i), 5'(31 - i));
      chk($sformatf("%s_rd1_%0d", tag, i), ReadData1, 32'd0);
      chk($sformatf("%s_rd2_%0d", tag, 31 - i), ReadData2, 32'd0);
    end
  endtask

  initial begin
    n_vec         = 0;
    n_miss        = 0;
    reset         = 1'b0;
    RegWrite      = 1'b0;
    WriteRegister = 5'd0;
    WriteData     = 32'd0;
    ReadRegister1 = 5'd0;
    ReadRegister2 = 5'd0;

    // Register 0 reads zero even before any reset.
    #2;
    chk("pre_reset_r0_p1", ReadData1, 32'd0);
    chk("pre_reset_r0_p2", ReadData2, 32'd0);

    // Test 1: fill, then reset with a competing write.
    for (int i = 1; i < 32; i++) wr(5'(i), 32'hFFFF_FFFF);
    rd(5'd31, 5'd1);
    chk("fill_r31", ReadData1, 32'hFFFF_FFFF);
    chk("fill_r1",  ReadData2, 32'hFFFF_FFFF);
    @(negedge clk);
    reset         = 1'b1;
    RegWrite      = 1'b1;
    WriteRegister = 5'd5;
    WriteData     = 32'd7;
    @(posedge clk);
    #1;
    reset    = 1'b0;
    RegWrite = 1'b0;
    sweep_zero("reset");

    // Test 2: back-to-back writes, zero-latency reads.
    wr(5'd2, 32'd151);
    wr(5'd3, 32'd56);
    rd(5'd2, 5'd3);
    chk("basic_r2", ReadData1, 32'd151);
    chk("basic_r3", ReadData2, 32'd56);

    // Test 3: writes to register 0 are discarded.
    wr(5'd0, 32'hDEAD_BEEF);
    rd(5'd0, 5'd0);
    chk("zero_reg_p1", ReadData1, 32'd0);
    chk("zero_reg_p2", ReadData2, 32'd0);

    // Test 4: RegWrite low leaves state alone.
    wr(5'd4, 32'd3);
    @(negedge clk);
    RegWrite      = 1'b0;
    WriteRegister = 5'd4;
    WriteData     = 32'd99;
    @(posedge clk);
    #1;
    rd(5'd4, 5'd4);
    chk("we_off_r4", ReadData1, 32'd3);

    // Test 5: read-during-write returns old value until the edge.
    wr(5'd7, 32'd10);
    @(negedge clk);
    RegWrite      = 1'b1;
    WriteRegister = 5'd7;
    WriteData     = 32'd20;
    ReadRegister1 = 5'd7;
    ReadRegister2 = 5'd7;
    #1;
    chk("rdw_before_p1", ReadData1, 32'd10);
    chk("rdw_before_p2", ReadData2, 32'd10);
    @(posedge clk);
    #1;
    RegWrite = 1'b0;
    chk("rdw_after_p1", ReadData1, 32'd20);
    chk("rdw_after_p2", ReadData2, 32'd20);

    // Test 6: decoder sweep, value i into register i.
    for (int i = 1; i < 32; i++) wr(5'(i), 32'(i));
    for (int i = 0; i < 32; i++) begin
      rd(5'(i), 5'(31 - i));
      chk($sformatf("sweep_rd1_%0d", i), ReadData1, 32'(i));
      chk($sformatf("sweep_rd2_%0d", 31 - i), ReadData2, 32'(31 - i));
    end

    // Reset held across several cycles with writes attempted each cycle.
    @(negedge clk);
    reset    = 1'b1;
    RegWrite = 1'b1;
    for (int k = 0; k < 3; k++) begin
      WriteRegister = 5'(9 + k);
      WriteData     = 32'hA5A5_0000 + 32'(k);
      @(posedge clk);
      @(negedge clk);
    end
    reset    = 1'b0;
    RegWrite = 1'b0;
    #1;
    sweep_zero("held_reset");

    // Post-reset writes still function.
    wr(5'd31, 32'h1234_5678);
    wr(5'd1,  32'h8765_4321);
    rd(5'd31, 5'd1);
    chk("post_reset_r31", ReadData1, 32'h1234_5678);
    chk("post_reset_r1",  ReadData2, 32'h8765_4321);
    rd(5'd2, 5'd30);
    chk("post_reset_r2",  ReadData1, 32'd0);
    chk("post_reset_r30", ReadData2, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/regfile_2r1w.md
Name: regfile_2r1w

Overview:
- 32-entry x 32-bit general-purpose register file for the CPU datapath.
- Sits directly upstream of the ALU-operand and writeback-select multiplexers (mux2/mux4), which consume its two read ports.
- Two combinational read ports and one clocked write port.
- Register 0 is hardwired to zero.
- Synchronous clear on reset.

Parameters:
- WIDTH, 32, data width of each register and of all data ports.
- ADDR_WIDTH, 5, register index width; depth is 2**ADDR_WIDTH (32).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high; clears every register at the rising edge of clk.
- RegWrite  input  1  write enable, sampled at rising edge.
- WriteRegister  input  ADDR_WIDTH  index of the register to write.
- WriteData  input  WIDTH  data to write.
- ReadRegister1  input  ADDR_WIDTH  index for read port 1.
- ReadRegister2  input  ADDR_WIDTH  index for read port 2.
- ReadData1  output  WIDTH  contents of register ReadRegister1.
- ReadData2  output  WIDTH  contents of register ReadRegister2.

Behaviour:
- One clock domain (clk); reset is synchronous and active-high; no asynchronous paths into state.
- Storage: registers 1..31 are WIDTH-bit flops. Register 0 has no storage and is a constant 0.
- Reset:
  - At a rising edge with reset=1, registers 1..31 become 0, regardless of RegWrite.
  - Reset has priority over write.
  - From the cycle after that edge, ReadData1 = ReadData2 = 0 for every index.
  - Before the first reset edge, contents are undefined (X permitted), except register 0, which reads 0.
- Write:
  - At a rising edge with reset=0 and RegWrite=1, register[WriteRegister] <= WriteData.
  - A write to index 0 is silently discarded.
  - RegWrite=0 leaves all state unchanged.
- Read:
  - Purely combinational, zero-cycle latency: ReadDataN = register[ReadRegisterN].
  - Index 0 always yields 0.
  - Both ports may address the same register and return identical values.
- Read-during-write, same index, same cycle:
  - The read returns the OLD value until the rising edge.
  - After the edge it returns WriteData.
  - No internal bypass; forwarding is the datapath's job.
- Latency: a write is visible on the read ports one clk edge after it is presented.
- Simultaneous reset and RegWrite: reset wins; the written register reads 0 after the edge.
- Reset held for multiple cycles: contents stay 0; all writes in those cycles are ignored.
- Reset asserted mid-program: all prior contents are lost at that edge; there is no partial clear.
- Out-of-range indices are impossible because depth = 2**ADDR_WIDTH.

Decomposition:
- Shared package: WIDTH and ADDR_WIDTH defaults, the REG_ZERO index constant (0), and the depth constant.
- Sub-module: decoder_1to32. It is a one-hot write-enable decoder taking (enable=RegWrite, address=WriteRegister) and producing 32 enable lines, with line 0 ignored.
- Read selection uses the existing 32:1 mux structure, built as a behavioural index or a tree of mux4/mux2.
- No new package types are needed beyond the constants above.

Test Plan:
1. Reset clear: write 32'hFFFFFFFF to regs 1..31, then assert reset for one edge with RegWrite=1, WriteRegister=5, WriteData=32'd7 -> all 32 indices read 0 on both ports (reset beats write).
2. Basic write/read: write 32'd151 to reg 2 and 32'd56 to reg 3 on consecutive edges. Then set ReadRegister1=2, ReadRegister2=3 -> ReadData1=151, ReadData2=56 with no extra cycle.
3. Zero register: RegWrite=1, WriteRegister=0, WriteData=32'hDEADBEEF, one edge -> ReadData1 with ReadRegister1=0 reads 32'd0.
4. Write enable off: reg 4 holds 32'd3; RegWrite=0, WriteRegister=4, WriteData=32'd99, one edge -> reg 4 still reads 3.
5. Read-during-write: reg 7 = 32'd10; present a write of 32'd20 to reg 7 with ReadRegister1=7 -> reads 10 before the edge and 20 after it. Both ports on index 7 match.
6. Decoder sweep: write value i to each reg i=1..31, then read all on both ports -> port reads i for i>0 and 0 for i=0. This confirms there is no aliasing between enable lines.
